dlsc_pcie_s6_tx_arbiter: RTL and testbench

Packet-atomic arbiter that shares the single 32-bit transmit TLP stream between three TLP generators: inbound-completion generator (source 0), outbound read-request generator (source 1) and outbound write-request generator (source 2). Sits between those generators' buffered TLP outputs and the Spartan-6 PCIe TX interface adapter. It grants one source per packet, passes beats through combinationally while granted, and gates each source with a per-source admission flag (credit/flow-control OK).

---
 rtl/dlsc_pcie_s6_tx_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_dlsc_pcie_s6_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_s6_tx_arbiter.sv
// dlsc_pcie_s6_tx_arbiter
// Packet-atomic arbiter sharing one TX TLP stream between three generators:
//   source 0 = inbound completions, 1 = outbound reads, 2 = outbound writes.
// One source is granted per packet. While granted, its beats pass straight
// through (zero latency; tx_ready -> src_ready is combinational).
// Optional build macro: DLSC_PCIE_S6_TX_ARB_CPL_PRIORITY_EN
//   defined   : completions (source 0) win whenever eligible; round-robin
//               among sources 1 and 2 otherwise.
//   undefined : plain 3-way round-robin.

module dlsc_pcie_s6_tx_arbiter #(
    parameter int DATA = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_disable,
    input  logic [2:0]          src_ok,
    output logic [2:0]          src_ready,
    input  logic [2:0]          src_valid,
    input  logic [3*DATA-1:0]   src_data,
    input  logic [2:0]          src_last,
    input  logic [2:0]          src_error,
    input  logic                tx_ready,
    output logic                tx_valid,
    output logic [DATA-1:0]     tx_data,
    output logic                tx_last,
    output logic                tx_error,
    output logic                arb_busy,
    output logic [1:0]          arb_grant
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } st_t;

    st_t        st_q;
    st_t        st_d;
    logic [1:0] grant_q;
    logic [1:0] grant_d;
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    logic [2:0] elig_s;
    logic       win_found_s;
    logic [1:0] win_idx_s;
    logic       win_upd_ptr_s;

    // Next index in modulo-3 order; an illegal value restarts at source 0.
    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        logic [1:0] r;
        case (v)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            2'd2:    r = 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Round-robin search ptr+1, ptr+2, ptr; returns {found, index}.
    function automatic logic [2:0] rr_pick3(input logic [1:0] ptr, input logic [2:0] elig);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] c3;
        logic [2:0] r;
        c1 = mod3_inc(ptr);
        c2 = mod3_inc(c1);
        c3 = mod3_inc(c2);
        if (elig[c1]) begin
            r = {1'b1, c1};
        end else if (elig[c2]) begin
            r = {1'b1, c2};
        end else if (elig[c3]) begin
            r = {1'b1, c3};
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Two-way round-robin between sources 1 and 2; returns {found, index}.
    function automatic logic [2:0] rr_pick12(input logic [1:0] ptr, input logic [2:0] elig);
        logic [2:0] r;
        if (ptr == 2'd1) begin
            if (elig[2]) begin
                r = {1'b1, 2'd2};
            end else if (elig[1]) begin
                r = {1'b1, 2'd1};
            end else begin
                r = 3'b000;
            end
        end else begin
            if (elig[1]) begin
                r = {1'b1, 2'd1};
            end else if (elig[2]) begin
                r = {1'b1, 2'd2};
            end else begin
                r = 3'b000;
            end
        end
        return r;
    endfunction

    // Eligibility: a source must present a beat, hold admission, and TX must be enabled.
    always_comb begin
        elig_s = src_valid & src_ok & {3{~tx_disable}};
    end

`ifdef DLSC_PCIE_S6_TX_ARB_CPL_PRIORITY_EN
    // Winner selection with completions first; pointer only tracks sources 1/2.
    always_comb begin
        logic [2:0] pick;
        pick = rr_pick12(ptr_q, elig_s);
        if (elig_s[0]) begin
            win_found_s   = 1'b1;
            win_idx_s     = 2'd0;
            win_upd_ptr_s = 1'b0;
        end else begin
            win_found_s   = pick[2];
            win_idx_s     = pick[1:0];
            win_upd_ptr_s = pick[2];
        end
    end
`else
    // Winner selection: plain 3-way round-robin starting after the last grant.
    always_comb begin
        logic [2:0] pick;
        pick          = rr_pick3(ptr_q, elig_s);
        win_found_s   = pick[2];
        win_idx_s     = pick[1:0];
        win_upd_ptr_s = pick[2];
    end
`endif

    // Beat steering: route the granted source to TX, idle drives all zeros.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = {DATA{1'b0}};
        tx_last   = 1'b0;
        tx_error  = 1'b0;
        src_ready = 3'b000;
        if (st_q == ST_PKT) begin
            case (grant_q)
                2'd0: begin
                    tx_valid     = src_valid[0];
                    tx_data      = src_data[0*DATA +: DATA];
                    tx_last      = src_last[0];
                    tx_error     = src_error[0];
                    src_ready[0] = tx_ready;
                end
                2'd1: begin
                    tx_valid     = src_valid[1];
                    tx_data      = src_data[1*DATA +: DATA];
                    tx_last      = src_last[1];
                    tx_error     = src_error[1];
                    src_ready[1] = tx_ready;
                end
                2'd2: begin
                    tx_valid     = src_valid[2];
                    tx_data      = src_data[2*DATA +: DATA];
                    tx_last      = src_last[2];
                    tx_error     = src_error[2];
                    src_ready[2] = tx_ready;
                end
                default: begin
                    tx_valid  = 1'b0;
                    tx_data   = {DATA{1'b0}};
                    tx_last   = 1'b0;
                    tx_error  = 1'b0;
                    src_ready = 3'b000;
                end
            endcase
        end else begin
            tx_valid  = 1'b0;
            tx_data   = {DATA{1'b0}};
            tx_last   = 1'b0;
            tx_error  = 1'b0;
            src_ready = 3'b000;
        end
    end

    // Next-state: grant on arbitration in idle, release after the last beat is accepted.
    always_comb begin
        st_d    = st_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (st_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    st_d    = ST_PKT;
                    grant_d = win_idx_s;
                    if (win_upd_ptr_s) begin
                        ptr_d = win_idx_s;
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    st_d    = ST_IDLE;
                    grant_d = grant_q;
                    ptr_d   = ptr_q;
                end
            end
            ST_PKT: begin
                if (tx_ready && tx_valid && tx_last) begin
                    st_d = ST_IDLE;
                end else begin
                    st_d = ST_PKT;
                end
            end
            default: begin
                st_d    = ST_IDLE;
                grant_d = 2'd0;
                ptr_d   = 2'd2;
            end
        endcase
    end

    // State registers; reset points ptr at source 2 so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            grant_q <= 2'd0;
            ptr_q   <= 2'd2;
        end else begin
            st_q    <= st_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Status outputs come straight from the state registers.
    always_comb begin
        arb_busy  = (st_q == ST_PKT);
        arb_grant = grant_q;
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_tx_arbiter.sv
// Directed self-checking bench for dlsc_pcie_s6_tx_arbiter.
// Each source is a simple packet generator whose beat data encodes
// {source id, packet number, beat number}; accepted TX beats are logged
// with their cycle number and compared against hand-derived sequences.

module tb_dlsc_pcie_s6_tx_arbiter;

    localparam int DATA = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                tx_disable;
    logic [2:0]          src_ok;
    logic [2:0]          src_ready;
    logic [2:0]          src_valid;
    logic [3*DATA-1:0]   src_data;
    logic [2:0]          src_last;
    logic [2:0]          src_error;
    logic                tx_ready;
    logic                tx_valid;
    logic [DATA-1:0]     tx_data;
    logic                tx_last;
    logic                tx_error;
    logic                arb_busy;
    logic [1:0]          arb_grant;

    logic [2:0]  valid_en;
    logic [2:0]  err_en;
    logic [15:0] len_v  [3];
    logic [7:0]  npkts  [3];
    logic [15:0] beat_r [3];
    logic [7:0]  pkt_r  [3];

    int          cyc = 0;
    logic [31:0] log_d [$];
    logic        log_l [$];
    logic        log_e [$];
    int          log_c [$];

    int checks   = 0;
    int failures = 0;
    int base;

    always #5 clk = ~clk;

    dlsc_pcie_s6_tx_arbiter #(.DATA(DATA)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_disable (tx_disable),
        .src_ok     (src_ok),
        .src_ready  (src_ready),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_last   (src_last),
        .src_error  (src_error),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_error   (tx_error),
        .arb_busy   (arb_busy),
        .arb_grant  (arb_grant)
    );

    // Source generators: present the current beat of the current packet.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            src_valid[i]             = valid_en[i] && (pkt_r[i] < npkts[i]);
            src_data[i*DATA +: DATA] = {8'(i), pkt_r[i], beat_r[i]};
            src_last[i]              = (beat_r[i] == len_v[i] - 16'd1);
            src_error[i]             = err_en[i];
        end
    end

    // Source generators advance on each accepted beat.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                beat_r[i] <= 16'd0;
                pkt_r[i]  <= 8'd0;
            end else if (src_valid[i] && src_ready[i]) begin
                if (src_last[i]) begin
                    beat_r[i] <= 16'd0;
                    pkt_r[i]  <= pkt_r[i] + 8'd1;
                end else begin
                    beat_r[i] <= beat_r[i] + 16'd1;
                end
            end
        end
    end

    // TX monitor: log every accepted beat with its cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && tx_valid && tx_ready) begin
            log_d.push_back(tx_data);
            log_l.push_back(tx_last);
            log_e.push_back(tx_error);
            log_c.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld(input int k);
        return (k < log_d.size()) ? log_d[k] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic ll(input int k);
        return (k < log_l.size()) ? log_l[k] : 1'bx;
    endfunction

    function automatic logic le(input int k);
        return (k < log_e.size()) ? log_e[k] : 1'bx;
    endfunction

    function automatic int lc(input int k);
        return (k < log_c.size()) ? log_c[k] : -1000;
    endfunction

    function automatic logic [31:0] beat_word(input int s, input int p, input int b);
        return {8'(s), 8'(p), 16'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (log_d.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq({tag, "_timeout"}, (log_d.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_beat(input int s, input int b, input string tag);
        int k;
        k = 0;
        while (beat_r[s] != 16'(b) && k < 50) begin
            tick();
            k++;
        end
        check_eq({tag, "_reach"}, {16'd0, beat_r[s]}, 32'(b));
    endtask

    initial begin
        rst        = 1'b1;
        tx_disable = 1'b0;
        tx_ready   = 1'b1;
        src_ok     = 3'b111;
        valid_en   = 3'b000;
        err_en     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            len_v[i] = 16'd4;
            npkts[i] = 8'd100;
        end

        // Reset state, with every source offering a packet.
        valid_en = 3'b111;
        tick();
        tick();
        @(negedge clk);
        check_eq("rst_busy",  {31'd0, arb_busy},  32'd0);
        check_eq("rst_grant", {30'd0, arb_grant}, 32'd0);
        check_eq("rst_valid", {31'd0, tx_valid},  32'd0);
        check_eq("rst_ready", {29'd0, src_ready}, 32'd0);
        check_eq("rst_data",  tx_data,            32'd0);
        check_eq("rst_last",  {31'd0, tx_last},   32'd0);
        check_eq("rst_err",   {31'd0, tx_error},  32'd0);

        // Round-robin of three 4-beat sources: 0,1,2,0 with one idle cycle between.
        tick();
        rst  = 1'b0;
        base = log_d.size();
        wait_log(base + 16, 200, "rr3");
        valid_en = 3'b000;
        for (int j = 0; j < 16; j++) begin
            int p;
            int b;
            p = j / 4;
            b = j % 4;
            check_eq($sformatf("rr3_data%0d", j), ld(base + j), beat_word(p % 3, p / 3, b));
            check_eq($sformatf("rr3_last%0d", j), {31'd0, ll(base + j)}, (b == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("rr3_cyc%0d", j), 32'(lc(base + j) - lc(base)), 32'(p * 5 + b));
        end

        // Source 1 blocked by src_ok, source 2 goes first; then source 1.
        valid_en = 3'b110;
        src_ok   = 3'b101;
        len_v[1] = 16'd2;
        len_v[2] = 16'd2;
        npkts[1] = 8'd1;
        npkts[2] = 8'd1;
        do_reset();
        base = log_d.size();
        wait_log(base + 1, 20, "ok_first");
        src_ok = 3'b111;
        wait_log(base + 4, 20, "ok_all");
        check_eq("ok_b0", ld(base + 0), beat_word(2, 0, 0));
        check_eq("ok_b1", ld(base + 1), beat_word(2, 0, 1));
        check_eq("ok_b2", ld(base + 2), beat_word(1, 0, 0));
        check_eq("ok_b3", ld(base + 3), beat_word(1, 0, 1));
        check_eq("ok_gap", 32'(lc(base + 2) - lc(base + 1)), 32'd2);

        // Source 0 stalls 3 cycles mid-packet; source 2 waits for it.
        valid_en = 3'b101;
        len_v[0] = 16'd4;
        len_v[2] = 16'd2;
        npkts[0] = 8'd1;
        npkts[2] = 8'd1;
        do_reset();
        base = log_d.size();
        wait_beat(0, 2, "stall");
        valid_en[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check_eq($sformatf("stall_valid%0d", s), {31'd0, tx_valid},  32'd0);
            check_eq($sformatf("stall_busy%0d", s),  {31'd0, arb_busy},  32'd1);
            check_eq($sformatf("stall_grant%0d", s), {30'd0, arb_grant}, 32'd0);
            tick();
        end
        valid_en[0] = 1'b1;
        wait_log(base + 6, 30, "stall_all");
        for (int j = 0; j < 4; j++) begin
            check_eq($sformatf("stall_s0b%0d", j), ld(base + j), beat_word(0, 0, j));
        end
        check_eq("stall_s2b0", ld(base + 4), beat_word(2, 0, 0));
        check_eq("stall_s2b1", ld(base + 5), beat_word(2, 0, 1));
        check_eq("stall_hole", 32'(lc(base + 2) - lc(base + 1)), 32'd4);
        check_eq("stall_gap",  32'(lc(base + 4) - lc(base + 3)), 32'd2);

        // tx_ready toggling on a 5-beat errored packet from source 1.
        valid_en = 3'b010;
        err_en   = 3'b010;
        len_v[1] = 16'd5;
        npkts[1] = 8'd1;
        do_reset();
        base = log_d.size();
        for (int c = 0; c < 40 && log_d.size() < base + 5; c++) begin
            tx_ready = (c % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (arb_busy) begin
                check_eq($sformatf("tog_ready%0d", c), {29'd0, src_ready}, {30'd0, tx_ready, 1'b0});
            end
            tick();
        end
        tx_ready = 1'b1;
        wait_log(base + 5, 5, "tog");
        for (int j = 0; j < 5; j++) begin
            check_eq($sformatf("tog_data%0d", j), ld(base + j), beat_word(1, 0, j));
            check_eq($sformatf("tog_err%0d", j),  {31'd0, le(base + j)}, 32'd1);
            check_eq($sformatf("tog_last%0d", j), {31'd0, ll(base + j)}, (j == 4) ? 32'd1 : 32'd0);
        end
        err_en = 3'b000;

        // tx_disable raised on beat 2 of 4: packet completes, then no grant until released.
        valid_en = 3'b001;
        len_v[0] = 16'd4;
        npkts[0] = 8'd2;
        do_reset();
        base = log_d.size();
        wait_beat(0, 1, "dis");
        tx_disable = 1'b1;
        wait_log(base + 4, 20, "dis_pkt");
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check_eq($sformatf("dis_busy%0d", s),  {31'd0, arb_busy}, 32'd0);
            check_eq($sformatf("dis_valid%0d", s), {31'd0, tx_valid}, 32'd0);
            tick();
        end
        check_eq("dis_count", 32'(log_d.size() - base), 32'd4);
        check_eq("dis_last",  {31'd0, ll(base + 3)}, 32'd1);
        tx_disable = 1'b0;
        @(negedge clk);
        check_eq("dis_rel_busy0", {31'd0, arb_busy}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("dis_rel_busy1", {31'd0, arb_busy}, 32'd1);
        check_eq("dis_rel_valid", {31'd0, tx_valid}, 32'd1);
        check_eq("dis_rel_data",  tx_data, beat_word(0, 1, 0));

        // Single-beat packets from sources 0 and 1, both continuously valid.
        valid_en = 3'b011;
        len_v[0] = 16'd1;
        len_v[1] = 16'd1;
        npkts[0] = 8'd100;
        npkts[1] = 8'd100;
        do_reset();
        base = log_d.size();
        wait_log(base + 6, 40, "pri");
        for (int j = 0; j < 6; j++) begin
`ifdef DLSC_PCIE_S6_TX_ARB_CPL_PRIORITY_EN
            check_eq($sformatf("pri_src%0d", j), ld(base + j), beat_word(0, j, 0));
`else
            check_eq($sformatf("pri_src%0d", j), ld(base + j), beat_word(j % 2, j / 2, 0));
`endif
            check_eq($sformatf("pri_last%0d", j), {31'd0, ll(base + j)}, 32'd1);
            check_eq($sformatf("pri_cyc%0d", j), 32'(lc(base + j) - lc(base)), 32'(j * 2));
        end

        // Reset mid-packet truncates immediately on the next edge.
        valid_en = 3'b001;
        len_v[0] = 16'd4;
        npkts[0] = 8'd1;
        do_reset();
        wait_beat(0, 2, "mrst");
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_busy_pre", {31'd0, arb_busy}, 32'd1);
        tick();
        @(negedge clk);
        check_eq("mrst_busy",  {31'd0, arb_busy},  32'd0);
        check_eq("mrst_valid", {31'd0, tx_valid},  32'd0);
        check_eq("mrst_last",  {31'd0, tx_last},   32'd0);
        check_eq("mrst_ready", {29'd0, src_ready}, 32'd0);
        tick();
        rst      = 1'b0;
        valid_en = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
